wb_uart_tx_slave: RTL and testbench

- Wishbone classic-pipelined responder that accepts the controller's setup and transmit-data writes and serialises bytes onto a UART TX line, 8N1.
- Sits behind the string-sending Wishbone controller as its bus target.
- Holds a baud-divisor register, a byte FIFO and a readable status register.

---
 rtl/wb_uart_tx_pkg.sv | 32 +++
 rtl/wbutx_fifo.sv | 45 ++++
 rtl/wb_uart_tx_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_uart_tx_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_tx_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map, STATUS layout, FSM encoding.
// Optional macro WB_UART_TX_PARITY_EN adds the PARITY state.
package wb_uart_tx_pkg;

    localparam logic [1:0] ADDR_SETUP  = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_TXDATA = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_LVL_LSB = 8;

    localparam int SETUP_PAR_BIT = 24;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS        = 10;
    localparam int FRAME_BITS_PARITY = 11;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef WB_UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } tx_state_t;

endpackage

// File: rtl/wbutx_fifo.sv
// Byte FIFO with asynchronous reset; dout shows the head entry combinationally while not empty.
// A pop in the same cycle as a push-while-full frees the slot for that push.
module wbutx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic do_push, do_pop;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/wb_uart_tx_slave.sv
// Wishbone target with divisor/status/txdata registers feeding an 8N1 UART transmitter.
// Define WB_UART_TX_PARITY_EN for an even-parity bit enabled by SETUP bit 24.
module wb_uart_tx_slave
    import wb_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int RESET_DIV  = 434,
    parameter int DIV_W      = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_uart_tx
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             req, wr_req, setup_wr, status_wr, push;
    logic             ack_reg, ovf_reg;
    logic [31:0]      rdata, rdata_reg;
    logic [DIV_W-1:0] div_reg, div_cand;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic [8:0]       level_wide;
    logic [7:0]       level_byte;
    logic             unused_bits;

    tx_state_t        state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next, div_lat_reg, div_lat_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       data_reg, data_next;
    logic             tx_reg, tx_next, load_frame;
`ifdef WB_UART_TX_PARITY_EN
    logic             par_en_reg, par_lat_reg, par_lat_next;
`endif

    assign req       = i_wb_cyc & i_wb_stb;
    assign wr_req    = req & i_wb_we;
    assign setup_wr  = wr_req & (i_wb_addr == ADDR_SETUP);
    assign status_wr = wr_req & (i_wb_addr == ADDR_STATUS);
    assign push      = wr_req & (i_wb_addr == ADDR_TXDATA) & i_wb_sel[0];

    assign o_wb_ack  = ack_reg;
    assign o_wb_data = rdata_reg;
    assign o_uart_tx = tx_reg;
    assign unused_bits = ^{i_wb_data, i_wb_sel};

    // Byte-lane merge of the write data over the current divisor.
    genvar gi;
    generate
        for (gi = 0; gi < DIV_W; gi++) begin : g_div_lane
            assign div_cand[gi] = i_wb_sel[gi/8] ? i_wb_data[gi] : div_reg[gi];
        end
    endgenerate

    wbutx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (fifo_pop),
        .din   (i_wb_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A depth-256 FIFO cannot show 256 in eight bits, so the level saturates.
    assign level_wide = 9'(fifo_level);
    assign level_byte = level_wide[8] ? 8'hFF : level_wide[7:0];

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            ADDR_SETUP: begin
                rdata = 32'(div_reg);
`ifdef WB_UART_TX_PARITY_EN
                rdata[SETUP_PAR_BIT] = par_en_reg;
`endif
            end
            ADDR_STATUS: begin
                rdata[ST_BUSY]           = (state_reg != S_IDLE);
                rdata[ST_EMPTY]          = fifo_empty;
                rdata[ST_FULL]           = fifo_full;
                rdata[ST_OVF]            = ovf_reg;
                rdata[ST_LVL_LSB +: 8]   = level_byte;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
            div_reg   <= DIV_W'(RESET_DIV);
            ovf_reg   <= 1'b0;
        end else begin
            ack_reg   <= req;
            rdata_reg <= (req & ~i_wb_we) ? rdata : '0;
            if (setup_wr && (div_cand > DIV_W'(1))) begin
                div_reg <= div_cand;
            end
            if (push && fifo_full && !fifo_pop) begin
                ovf_reg <= 1'b1;
            end else if (status_wr && i_wb_sel[0] && i_wb_data[ST_OVF]) begin
                ovf_reg <= 1'b0;
            end
        end
    end

`ifdef WB_UART_TX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_en_reg  <= 1'b0;
            par_lat_reg <= 1'b0;
        end else begin
            if (setup_wr && i_wb_sel[3]) par_en_reg <= i_wb_data[SETUP_PAR_BIT];
            par_lat_reg <= par_lat_next;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            div_lat_reg <= DIV_W'(RESET_DIV);
            idx_reg     <= '0;
            data_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_lat_reg <= div_lat_next;
            idx_reg     <= idx_next;
            data_reg    <= data_next;
            tx_reg      <= tx_next;
        end
    end

    // Every bit lasts div_lat clocks: the counter is reloaded with div-1 on each bit boundary.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_lat_next = div_lat_reg;
        idx_next     = idx_reg;
        data_next    = data_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;
        load_frame   = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
        par_lat_next = par_lat_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) load_frame = 1'b1;
            end
            S_START: begin
                if (cnt_reg == '0) begin
                    state_next = S_DATA;
                    cnt_next   = div_lat_reg - DIV_W'(1);
                    idx_next   = '0;
                    tx_next    = data_reg[0];
                end else begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == '0) begin
                    cnt_next = div_lat_reg - DIV_W'(1);
                    if (idx_reg == LAST_BIT_IDX) begin
`ifdef WB_UART_TX_PARITY_EN
                        if (par_lat_reg) begin
                            state_next = S_PARITY;
                            tx_next    = ^data_reg;
                        end else begin
                            state_next = S_STOP;
                            tx_next    = 1'b1;
                        end
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = data_reg[idx_reg + 3'd1];
                    end
                end else begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end
            end
`ifdef WB_UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == '0) begin
                    state_next = S_STOP;
                    cnt_next   = div_lat_reg - DIV_W'(1);
                    tx_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_reg == '0) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Pop and latch per-frame settings; the start bit appears on the line next cycle.
        if (load_frame) begin
            fifo_pop     = 1'b1;
            state_next   = S_START;
            data_next    = fifo_dout;
            div_lat_next = div_reg;
            cnt_next     = div_reg - DIV_W'(1);
            tx_next      = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
            par_lat_next = par_en_reg;
`endif
        end
    end

endmodule

// File: tb/tb_wb_uart_tx_slave.sv
// Directed bench: register vector table plus frame-timing sequences on a 16-deep and a 4-deep instance.
module tb_wb_uart_tx_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    int          which = 0;

    logic        cyc0, cyc1, ack0, ack1, tx0, tx1, ack_m, tx_m;
    logic [31:0] rd0, rd1, rdata_m;

    int tests = 0;
    int fails = 0;

    logic [7:0] frame_bytes [16];

    typedef struct packed {
        logic [1:0]  addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [23];

    always #5 clk = ~clk;

    assign cyc0    = cyc & (which == 0);
    assign cyc1    = cyc & (which == 1);
    assign ack_m   = (which == 1) ? ack1 : ack0;
    assign rdata_m = (which == 1) ? rd1 : rd0;
    assign tx_m    = (which == 1) ? tx1 : tx0;

    wb_uart_tx_slave #(.FIFO_DEPTH(16), .RESET_DIV(434), .DIV_W(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc0), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_sel(sel), .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_ack(ack0), .o_wb_data(rd0), .o_uart_tx(tx0)
    );

    wb_uart_tx_slave #(.FIFO_DEPTH(4), .RESET_DIV(434), .DIV_W(24)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_sel(sel), .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_ack(ack1), .o_wb_data(rd1), .o_uart_tx(tx1)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One request; returns at the sample point of the ack cycle.
    task automatic bus(input logic [1:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rv, output logic av);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdata = d;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        av = ack_m;
        rv = rdata_m;
        $display("[TB] dut%0d %s addr=%0d sel=%h wdata=%08h ack=%b rdata=%08h",
                 which, w ? "WR" : "RD", a, s, d, av, rv);
    endtask

    task automatic do_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] r;
        logic k;
        bus(a, 1'b0, 4'hF, 32'h0, r, k);
        check32({nm, "/ack"}, {31'b0, k}, 32'd1);
        check32(nm, r, exp);
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d, input string nm);
        logic [31:0] r;
        logic k;
        bus(a, 1'b1, s, d, r, k);
        check32({nm, "/ack"}, {31'b0, k}, 32'd1);
    endtask

    // Back-to-back TXDATA pushes of frame_bytes[0..n-1], stb held high throughout.
    task automatic burst(input int n);
        int bad;
        bad = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd3; sel = 4'h1;
        for (int i = 0; i < n; i++) begin
            wdata = {24'h0, frame_bytes[i]};
            @(posedge clk); #1;
            $display("[TB] dut%0d WR addr=3 push %02h ack=%b", which, frame_bytes[i], ack_m);
            if (ack_m !== 1'b1) bad++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check32("burst acks missing", 32'(bad), 32'd0);
        @(posedge clk); #1;
        check32("ack after burst", {31'b0, ack_m}, 32'd0);
    endtask

    // Called at the sample point of the first start-bit cycle; checks every cycle of n frames.
    task automatic check_frames(input int n, input int div, input bit par, input string nm);
        int nbits, pos, err;
        logic exp;
        nbits = par ? 11 : 10;
        for (int f = 0; f < n; f++) begin
            err = 0;
            for (int k = 0; k < nbits * div; k++) begin
                pos = k / div;
                if (pos == 0)      exp = 1'b0;
                else if (pos <= 8) exp = frame_bytes[f][pos-1];
                else if (pos == 9 && par) exp = ^frame_bytes[f];
                else               exp = 1'b1;
                if (tx_m !== exp && err == 0) begin
                    err = 1;
                    $display("FAIL %s frame %0d: tx=%b expected %b at cycle %0d", nm, f, tx_m, exp, k);
                end
                @(posedge clk); #1;
            end
            tests++;
            if (err != 0) fails++;
            $display("[TB] dut%0d frame %0d byte %02h checked", which, f, frame_bytes[f]);
        end
        check32({nm, " idle after"}, {31'b0, tx_m}, 32'd1);
    endtask

    task automatic check_idle(input int n, input string nm);
        int err;
        err = 0;
        for (int k = 0; k < n; k++) begin
            if (tx_m !== 1'b1) err++;
            @(posedge clk); #1;
        end
        check32(nm, 32'(err), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd434};
        vecs[1]  = '{2'd1, 1'b0, 4'hF, 32'h0,        32'h2};
        vecs[2]  = '{2'd2, 1'b0, 4'hF, 32'h0,        32'h0};
        vecs[3]  = '{2'd3, 1'b0, 4'hF, 32'h0,        32'h0};
        vecs[4]  = '{2'd2, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[5]  = '{2'd2, 1'b0, 4'hF, 32'h0,        32'h0};
        vecs[6]  = '{2'd0, 1'b1, 4'hF, 32'd8,        32'h0};
        vecs[7]  = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd8};
        vecs[8]  = '{2'd0, 1'b1, 4'hF, 32'd1,        32'h0};
        vecs[9]  = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd8};
        vecs[10] = '{2'd0, 1'b1, 4'h1, 32'h0,        32'h0};
        vecs[11] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd8};
        vecs[12] = '{2'd0, 1'b1, 4'h2, 32'h00000100, 32'h0};
        vecs[13] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'h108};
        vecs[14] = '{2'd0, 1'b1, 4'h2, 32'h0,        32'h0};
        vecs[15] = '{2'd0, 1'b1, 4'h8, 32'hFF000000, 32'h0};
`ifdef WB_UART_TX_PARITY_EN
        vecs[16] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'h01000008};
`else
        vecs[16] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd8};
`endif
        vecs[17] = '{2'd0, 1'b1, 4'hF, 32'd8,        32'h0};
        vecs[18] = '{2'd0, 1'b0, 4'hF, 32'h0,        32'd8};
        vecs[19] = '{2'd1, 1'b1, 4'h1, 32'h8,        32'h0};
        vecs[20] = '{2'd3, 1'b1, 4'hE, 32'h55,       32'h0};
        vecs[21] = '{2'd1, 1'b0, 4'hF, 32'h0,        32'h2};
        vecs[22] = '{2'd3, 1'b0, 4'hF, 32'h0,        32'h0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check32("reset tx", {31'b0, tx0}, 32'd1);
        check32("reset ack", {31'b0, ack0}, 32'd0);
        check32("reset rdata", rd0, 32'd0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // Register vector table.
        which = 0;
        for (int i = 0; i < 23; i++) begin
            logic [31:0] r;
            logic k;
            bus(vecs[i].addr, vecs[i].we, vecs[i].sel, vecs[i].data, r, k);
            check32($sformatf("vec%0d ack", i), {31'b0, k}, 32'd1);
            check32($sformatf("vec%0d data", i), r, vecs[i].exp);
            @(posedge clk); #1;
            check32($sformatf("vec%0d idle bus", i), {ack_m, rdata_m[30:0]}, 32'd0);
        end
        check32("tx idle after table", {31'b0, tx0}, 32'd1);

        // Single 'G' frame at divisor 8, with a STATUS read during the frame.
        frame_bytes[0] = 8'h47;
        fork
            begin
                do_wr(2'd3, 4'h1, 32'h47, "push G");
                check32("tx high at N+1", {31'b0, tx0}, 32'd1);
                repeat (20) @(posedge clk);
                #1;
                do_rd(2'd1, 32'h3, "status busy");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check_frames(1, 8, 1'b0, "G frame");
            end
        join
        do_rd(2'd1, 32'h2, "status after G");

        // Ten queued bytes must go out as contiguous frames.
        {frame_bytes[0], frame_bytes[1], frame_bytes[2], frame_bytes[3], frame_bytes[4]} = {8'h47, 8'h55, 8'h4C, 8'h20, 8'h42};
        {frame_bytes[5], frame_bytes[6], frame_bytes[7], frame_bytes[8], frame_bytes[9]} = {8'h41, 8'h48, 8'h41, 8'h52, 8'h0A};
        fork
            begin
                burst(10);
                do_rd(2'd1, 32'h00000901, "status level 9");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check_frames(10, 8, 1'b0, "string frames");
            end
        join
        do_rd(2'd1, 32'h2, "status after string");

        // Reset in the middle of a data bit.
        frame_bytes[0] = 8'h00; frame_bytes[1] = 8'h00; frame_bytes[2] = 8'h00;
        burst(3);
        repeat (8) @(posedge clk);
        #1;
        check32("tx low before reset", {31'b0, tx0}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check32("tx async reset", {31'b0, tx0}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        do_rd(2'd1, 32'h2, "status after reset");
        do_rd(2'd0, 32'd434, "setup after reset");
        check_idle(40, "fifo discarded");

`ifdef WB_UART_TX_PARITY_EN
        do_wr(2'd0, 4'hF, 32'h01000008, "setup parity");
        frame_bytes[0] = 8'h07;
        fork
            burst(1);
            begin
                repeat (2) @(posedge clk);
                #1;
                check_frames(1, 8, 1'b1, "parity frame");
            end
        join
        check32("parity bit of 07", {31'b0, ^frame_bytes[0]}, 32'd1);
`endif

        // Overflow on the 4-deep instance.
        which = 1;
        do_wr(2'd0, 4'h3, 32'd1000, "dut4 setup");
        do_rd(2'd0, 32'd1000, "dut4 setup rb");
        {frame_bytes[0], frame_bytes[1], frame_bytes[2]} = {8'h11, 8'h22, 8'h33};
        {frame_bytes[3], frame_bytes[4], frame_bytes[5]} = {8'h44, 8'h55, 8'h66};
        fork
            begin
                burst(6);
                do_rd(2'd1, 32'h0000040D, "status overflow");
                do_wr(2'd1, 4'h1, 32'h8, "clear overflow");
                do_rd(2'd1, 32'h00000405, "status cleared");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check_frames(5, 1000, 1'b0, "overflow frames");
            end
        join
        check_idle(3000, "no sixth frame");
        do_rd(2'd1, 32'h2, "dut4 status end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
